// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and column encoding for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Nibble {row,col} holds the code printed on that Pmod KYPD key
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    int idx;
    idx = 4 * int'({row, col});
    return KEY_MAP[idx +: 4];
  endfunction

  function automatic logic [3:0] col_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and decoded key outputs
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output col, output key, output key_valid, output key_held);
  modport slave  (output row, input col, input key, input key_valid, input key_held);

endinterface

// File: rtl/keypad_tick.sv
// rtl/keypad_tick.sv - free-running divider producing a one-cycle sample strobe
module keypad_tick #(
  parameter int DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));
  assign o_tick = w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row debounce and key decode
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  keypad_scanner_if.master   kp
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    r_row_m;
  logic [3:0]    r_row_s;
  logic [1:0]    r_col;
  state_e        r_state;
  logic [1:0]    r_cand_row;
  logic [CW-1:0] r_match;
  logic [CW-1:0] r_rel;
  logic [3:0]    r_key;
  logic          r_key_valid;
  logic          r_key_held;

  logic          w_tick;
  logic          w_hit;
  logic [1:0]    w_hit_row;
  logic          w_cand_hit;

  keypad_tick #(.DIV(SCAN_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row_m <= 4'hF;
      r_row_s <= 4'hF;
    end else begin
      r_row_m <= kp.row;
      r_row_s <= r_row_m;
    end
  end

  // Descending scan so the lowest low row is the one left standing
  always_comb begin
    w_hit     = ~&r_row_s;
    w_hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_s[i]) w_hit_row = 2'(i);
    end
    w_cand_hit = !r_row_s[r_cand_row];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col       <= 2'd0;
      r_state     <= SCAN;
      r_cand_row  <= 2'd0;
      r_match     <= '0;
      r_rel       <= '0;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_hit) begin
              r_cand_row <= w_hit_row;
              r_match    <= CW'(1);
              r_state    <= DEBOUNCE;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (w_hit && (w_hit_row == r_cand_row)) begin
              if (r_match == CW'(DEBOUNCE_SCANS - 1)) begin
                r_key       <= key_lookup(r_cand_row, r_col);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_rel       <= '0;
                r_state     <= HELD;
              end else begin
                r_match <= r_match + 1'b1;
              end
            end else begin
              r_state <= SCAN;
              r_col   <= r_col + 2'd1;
            end
          end
          HELD: begin
            if (w_cand_hit) begin
              r_rel <= '0;
            end else if (r_rel == CW'(DEBOUNCE_SCANS - 1)) begin
              r_key_held <= 1'b0;
              r_state    <= SCAN;
              r_col      <= r_col + 2'd1;
            end else begin
              r_rel <= r_rel + 1'b1;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

  assign kp.col       = col_onehot_low(r_col);
  assign kp.key       = r_key;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] pressed;
  int          total;
  int          bad;
  int          n_pulses;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (kp.key_valid) n_pulses <= n_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n;
    n = 0;
    while (!kp.key_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(kp.key_valid), 1);
  endtask

  task automatic wait_release(input int bound, input string tag);
    int n;
    n = 0;
    while (kp.key_held && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(kp.key_held), 0);
  endtask

  task automatic wait_col(input logic [3:0] exp, input int bound, input string tag);
    int n;
    n = 0;
    while (kp.col != exp && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(kp.col), 32'(exp));
  endtask

  logic [3:0] col_tab [4];

  initial begin
    col_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    total    = 0;
    bad      = 0;
    n_pulses = 0;
    pressed  = 16'h0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(kp.col), 32'b1110);
    check("rst_key", 32'(kp.key), 0);
    check("rst_valid", 32'(kp.key_valid), 0);
    check("rst_held", 32'(kp.key_held), 0);

    // 1: idle scan, one column per 4-cycle slot
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_col%0d", k), 32'(kp.col), 32'(col_tab[k % 4]));
      repeat (4) @(negedge clk);
    end
    check("t1_pulses", n_pulses, 0);
    check("t1_key", 32'(kp.key), 0);

    // 2: clean press of '5'
    pressed[5] = 1'b1;
    wait_valid(40, "t2_valid");
    @(negedge clk);
    check("t2_key", 32'(kp.key), 5);
    check("t2_held", 32'(kp.key_held), 1);
    check("t2_col", 32'(kp.col), 32'b1101);
    repeat (40) @(negedge clk);
    check("t2_col_frozen", 32'(kp.col), 32'b1101);
    check("t2_pulses", n_pulses, 1);

    // 3: release resumes scanning at column 2
    pressed = 16'h0;
    wait_release(30, "t3_release");
    check("t3_col", 32'(kp.col), 32'b1011);
    check("t3_key", 32'(kp.key), 5);

    // 4: one-strobe bounce on 'D' then a stable press
    wait_col(4'b0111, 20, "t4_col3");
    pressed[15] = 1'b1;
    repeat (4) @(negedge clk);
    pressed[15] = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_bounce_pulses", n_pulses, 1);
    pressed[15] = 1'b1;
    wait_valid(40, "t4_valid");
    @(negedge clk);
    check("t4_key", 32'(kp.key), 32'hD);
    check("t4_pulses", n_pulses, 2);
    pressed = 16'h0;
    wait_release(30, "t4_release");

    // 5: '1' and '7' together, then '9' while '1' held
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    wait_valid(40, "t5_valid1");
    @(negedge clk);
    check("t5_key1", 32'(kp.key), 1);
    pressed[10] = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_no_second", n_pulses, 3);
    check("t5_key_hold", 32'(kp.key), 1);
    check("t5_col", 32'(kp.col), 32'b1110);
    pressed[0] = 1'b0;
    pressed[8] = 1'b0;
    wait_valid(60, "t5_valid9");
    @(negedge clk);
    check("t5_key9", 32'(kp.key), 9);
    check("t5_pulses", n_pulses, 4);
    pressed = 16'h0;
    wait_release(30, "t5_release");

    // 6a: reset while debouncing '5'
    wait_col(4'b1101, 20, "t6_col1");
    pressed[5] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6a_col", 32'(kp.col), 32'b1110);
    check("t6a_key", 32'(kp.key), 0);
    check("t6a_valid", 32'(kp.key_valid), 0);
    check("t6a_held", 32'(kp.key_held), 0);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6a_no_stray", n_pulses, 4);

    // 6b: reset while holding '5', asserted between edges
    pressed[5] = 1'b1;
    wait_valid(40, "t6b_valid");
    @(negedge clk);
    check("t6b_held_pre", 32'(kp.key_held), 1);
    check("t6b_key_pre", 32'(kp.key), 5);
    #2;
    rst = 1'b1;
    #1;
    check("t6b_col", 32'(kp.col), 32'b1110);
    check("t6b_key", 32'(kp.key), 0);
    check("t6b_held", 32'(kp.key_held), 0);
    check("t6b_valid", 32'(kp.key_valid), 0);
    pressed = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6b_no_stray", n_pulses, 5);
    check("t6b_key_after", 32'(kp.key), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
